planificador_multiplicador: RTL

Arbiter plus sequencer that shares one signed Booth multiplier datapath (camino_datos style: A, Q, M registers and a qsub1 flip-flop) between two requesters. It picks a requester round-robin, muxes that requester's operands into the datapath, and drives the load, add/sub and shift controls for N iterations. It then latches the 2N-bit product and returns it to the granted requester with a one-cycle done pulse.

---
 rtl/planificador_multiplicador_pkg.sv | 26 ++
 rtl/planificador_multiplicador_uc.sv | 99 +++++++++
 rtl/planificador_multiplicador.sv | 96 +++++++++
 3 files changed

// File: rtl/planificador_multiplicador_pkg.sv
// Shared definitions for the Booth multiplier scheduler.
// Holds the sequencer state encoding, the default operand width and the
// Booth recoding constants for the {q0, qsub1} pair.
package planificador_multiplicador_pkg;

  // Default operand width; the product is twice this wide.
  localparam int N_DEF = 3;

  // Sequencer states. IDLE waits for a request, LOAD fills M and Q, then
  // EVAL/SHIFT alternate once per multiplier bit, CAPT latches the product
  // and RESP returns it to the granted requester.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    SHIFT = 3'd3,
    CAPT  = 3'd4,
    RESP  = 3'd5
  } estado_t;

  // Booth codes for {q0, qsub1}: 10 starts a run of ones (subtract M),
  // 01 ends one (add M). 00 and 11 only shift.
  localparam logic [1:0] BOOTH_RESTA = 2'b10;
  localparam logic [1:0] BOOTH_SUMA  = 2'b01;

endpackage

// File: rtl/planificador_multiplicador_uc.sv
// uc_booth_n: control unit that sequences one signed Booth multiplication
// on the shared datapath.
// Ports:
//   clk, reset        clock and asynchronous active-low reset
//   start             a requester is waiting (sampled only in IDLE)
//   q0, qsub1         datapath Booth bits
//   carga_m, carga_q  load M / load Q (datapath also clears A and qsub1)
//   carga_a, resta    load A with A-M (resta=1) or A+M (resta=0)
//   desplaza          arithmetic shift right of {A,Q,qsub1}
//   capturar          product is final, latch it this cycle
//   fin               one-cycle completion pulse
//   busy              high in every state except IDLE
module uc_booth_n
  import planificador_multiplicador_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic q0,
  input  logic qsub1,
  output logic carga_m,
  output logic carga_q,
  output logic carga_a,
  output logic resta,
  output logic desplaza,
  output logic capturar,
  output logic fin,
  output logic busy
);

  localparam int CW = $clog2(N + 1);

  estado_t estado, estadoSig;
  logic [CW-1:0] contador;

  // State register; reset abandons any multiplication in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) estado <= IDLE;
    else        estado <= estadoSig;
  end

  // Iteration counter: cleared when the operands are loaded and advanced
  // once per shift, so it holds the number of completed iterations.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                contador <= '0;
    else if (estado == LOAD)   contador <= '0;
    else if (estado == SHIFT)  contador <= contador + 1'b1;
  end

  // Next-state logic. The last shift is recognised by the count before it
  // is incremented, i.e. when N-1 iterations are already complete.
  always_comb begin
    estadoSig = estado;
    case (estado)
      IDLE:    if (start) estadoSig = LOAD;
      LOAD:    estadoSig = EVAL;
      EVAL:    estadoSig = SHIFT;
      SHIFT:   estadoSig = (contador == CW'(N - 1)) ? CAPT : EVAL;
      CAPT:    estadoSig = RESP;
      RESP:    estadoSig = IDLE;
      default: estadoSig = IDLE;
    endcase
  end

  // Output decode. Everything is a function of the state except the
  // add/subtract choice in EVAL, which follows the live Booth bits.
  always_comb begin
    carga_m  = 1'b0;
    carga_q  = 1'b0;
    carga_a  = 1'b0;
    resta    = 1'b0;
    desplaza = 1'b0;
    capturar = 1'b0;
    fin      = 1'b0;
    case (estado)
      LOAD: begin
        carga_m = 1'b1;
        carga_q = 1'b1;
      end
      EVAL: begin
        if ({q0, qsub1} == BOOTH_RESTA) begin
          carga_a = 1'b1;
          resta   = 1'b1;
        end else if ({q0, qsub1} == BOOTH_SUMA) begin
          carga_a = 1'b1;
        end
      end
      SHIFT:   desplaza = 1'b1;
      CAPT:    capturar = 1'b1;
      RESP:    fin      = 1'b1;
      default: ;
    endcase
  end

  assign busy = (estado != IDLE);

endmodule

// File: rtl/planificador_multiplicador.sv
// planificador_multiplicador: shares one signed Booth multiplier datapath
// between two requesters with round-robin arbitration.
// Ports:
//   clk, reset                          clock, asynchronous active-low reset
//   req0/1, multiplicando0/1,
//   multiplicador0/1                    requests and their signed operands
//   q0, qsub1, producto                 datapath feedback ({A,Q} as producto)
//   entrada_m, entrada_q                selected operands to the datapath
//   CargaM, CargaQ, CargaA, resta,
//   desplaza                            datapath controls
//   resultado                           last product, held until replaced
//   done0, done1                        one-cycle completion pulses
//   busy                                a job is in progress
module planificador_multiplicador
  import planificador_multiplicador_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req0,
  input  logic [N-1:0]   multiplicando0,
  input  logic [N-1:0]   multiplicador0,
  input  logic           req1,
  input  logic [N-1:0]   multiplicando1,
  input  logic [N-1:0]   multiplicador1,
  input  logic           q0,
  input  logic           qsub1,
  input  logic [2*N-1:0] producto,
  output logic [N-1:0]   entrada_m,
  output logic [N-1:0]   entrada_q,
  output logic           CargaM,
  output logic           CargaQ,
  output logic           CargaA,
  output logic           resta,
  output logic           desplaza,
  output logic [2*N-1:0] resultado,
  output logic           done0,
  output logic           done1,
  output logic           busy
);

  logic sel;
  logic ultimo;
  logic ocupado;
  logic capturar;
  logic fin;

  // Grant register. A new grant is only taken while the sequencer is idle,
  // so sel stays stable for the whole job and also steers done routing.
  // On a tie the requester not served last wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      sel <= 1'b0;
    else if (!ocupado && (req0 || req1))
      sel <= (req0 && req1) ? ~ultimo : req1;
  end

  // Product latch and round-robin history, both updated when the
  // sequencer declares the product final. ultimo starts at 1 so that
  // requester 0 wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resultado <= '0;
      ultimo    <= 1'b1;
    end else if (capturar) begin
      resultado <= producto;
      ultimo    <= sel;
    end
  end

  // Operand mux follows the registered grant.
  assign entrada_m = sel ? multiplicando1 : multiplicando0;
  assign entrada_q = sel ? multiplicador1 : multiplicador0;

  assign done0 = fin & ~sel;
  assign done1 = fin &  sel;
  assign busy  = ocupado;

  uc_booth_n #(.N(N)) u_uc (
    .clk      (clk),
    .reset    (reset),
    .start    (req0 | req1),
    .q0       (q0),
    .qsub1    (qsub1),
    .carga_m  (CargaM),
    .carga_q  (CargaQ),
    .carga_a  (CargaA),
    .resta    (resta),
    .desplaza (desplaza),
    .capturar (capturar),
    .fin      (fin),
    .busy     (ocupado)
  );

endmodule
